// File: rtl/tri_aoi21_skid_if.sv
// Handshake bundle for tri_aoi21_skid: upstream AOI21 operands in, registered
// result out, plus entry count for observability.
interface tri_aoi21_skid_if #(
    parameter int WIDTH = 1
);
    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b0;
    logic             out_vld;
    logic             out_rdy;
    logic [WIDTH-1:0] out_y;
    logic             out_par;
    logic [1:0]       occ;

    modport master (
        output in_vld, a0, a1, b0, out_rdy,
        input  in_rdy, out_vld, out_y, out_par, occ
    );

    modport slave (
        input  in_vld, a0, a1, b0, out_rdy,
        output in_rdy, out_vld, out_y, out_par, occ
    );
endinterface

// File: rtl/tri_aoi21_skid.sv
// Registered AOI21 stage (y = ~((a0&a1)|b0)) with even parity, behind a
// two-entry skid buffer so in_rdy depends only on registered state.
module tri_aoi21_skid #(
    parameter int               WIDTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             nclk,
    input  logic             rst,
    input  logic             act,
    tri_aoi21_skid_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_y_q, main_y_d;
    logic             main_par_q, main_par_d;
    logic [WIDTH-1:0] skid_y_q, skid_y_d;
    logic             skid_par_q, skid_par_d;

    logic [WIDTH-1:0] new_y;
    logic             new_par;
    logic             in_rdy, out_vld, push, pop;

    assign new_y   = ~((bus.a0 & bus.a1) | bus.b0);
    assign new_par = ^new_y;

    // Both handshakes are suppressed during reset so nothing is accepted or
    // presented in a cycle whose state is about to be discarded.
    assign in_rdy  = act & ~rst & (state_q != TWO);
    assign out_vld = act & ~rst & (state_q != EMPTY);
    assign push    = bus.in_vld & in_rdy;
    assign pop     = out_vld & bus.out_rdy;

    always_comb begin
        state_d    = state_q;
        main_y_d   = main_y_q;
        main_par_d = main_par_q;
        skid_y_d   = skid_y_q;
        skid_par_d = skid_par_q;
        if (act) begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d    = ONE;
                        main_y_d   = new_y;
                        main_par_d = new_par;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_y_d   = new_y;
                        main_par_d = new_par;
                    end else if (push) begin
                        state_d    = TWO;
                        skid_y_d   = new_y;
                        skid_par_d = new_par;
                    end else if (pop) begin
                        state_d    = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d    = ONE;
                        main_y_d   = skid_y_q;
                        main_par_d = skid_par_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge nclk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_y_q   <= INIT;
            main_par_q <= ^INIT;
            skid_y_q   <= INIT;
            skid_par_q <= ^INIT;
        end else if (act) begin
            state_q    <= state_d;
            main_y_q   <= main_y_d;
            main_par_q <= main_par_d;
            skid_y_q   <= skid_y_d;
            skid_par_q <= skid_par_d;
        end
    end

    assign bus.in_rdy  = in_rdy;
    assign bus.out_vld = out_vld;
    assign bus.out_y   = main_y_q;
    assign bus.out_par = main_par_q;
    assign bus.occ     = state_q;
endmodule

// File: tb/tb_tri_aoi21_skid.sv
// Directed bench for tri_aoi21_skid: stimulus pushes hand-computed results
// into a queue on acceptance; a monitor pops and compares on every pop.
module tb_tri_aoi21_skid;
    logic nclk = 1'b0;
    logic rst  = 1'b1;
    logic act  = 1'b1;

    int checks   = 0;
    int failures = 0;
    logic [4:0] exp_q[$];

    tri_aoi21_skid_if #(.WIDTH(4)) bus ();

    tri_aoi21_skid #(.WIDTH(4), .INIT(4'b0000)) dut (
        .nclk (nclk),
        .rst  (rst),
        .act  (act),
        .bus  (bus)
    );

    always #5 nclk = ~nclk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Called at a negedge; offers one vector until accepted, returns at the
    // negedge after the accepting edge with in_vld dropped.
    task automatic send(input logic [3:0] x0, input logic [3:0] x1, input logic [3:0] xb,
                        input logic [3:0] ey, input logic ep, output int waits);
        bus.in_vld = 1'b1;
        bus.a0 = x0; bus.a1 = x1; bus.b0 = xb;
        waits = 0;
        while (1) begin
            #1;
            if (bus.in_rdy) begin
                exp_q.push_back({ep, ey});
                @(negedge nclk);
                break;
            end
            waits++;
            if (waits > 50) begin
                check("send_timeout", 32'(waits), 0);
                @(negedge nclk);
                break;
            end
            @(negedge nclk);
        end
        bus.in_vld = 1'b0;
        bus.a0 = 'x; bus.a1 = 'x; bus.b0 = 'x;
    endtask

    // Monitor: compares each popped result against the queue head.
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge nclk);
            #2;
            if (bus.out_vld && bus.out_rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {27'd0, bus.out_par, bus.out_y}, 32'h1f);
                end else begin
                    e = exp_q.pop_front();
                    check("out_y", 32'(bus.out_y), 32'(e[3:0]));
                    check("out_par", 32'(bus.out_par), 32'(e[4]));
                end
            end
        end
    end

    logic [3:0] t4_a0 [8] = '{4'b0000, 4'b1111, 4'b1010, 4'b0011, 4'b0000, 4'b1100, 4'b1001, 4'b0110};
    logic [3:0] t4_a1 [8] = '{4'b0000, 4'b1111, 4'b1111, 4'b0110, 4'b0000, 4'b1100, 4'b0001, 4'b1110};
    logic [3:0] t4_b0 [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0011, 4'b0100, 4'b0001};
    logic [3:0] t4_y  [8] = '{4'b1111, 4'b0000, 4'b0101, 4'b1101, 4'b0111, 4'b0000, 4'b1010, 4'b1000};
    logic       t4_p  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int w;
        bus.in_vld = 1'b0; bus.out_rdy = 1'b1;
        bus.a0 = 'x; bus.a1 = 'x; bus.b0 = 'x;

        // 1: reset and idle
        @(negedge nclk);
        check("rst_in_rdy", 32'(bus.in_rdy), 0);
        check("rst_out_vld", 32'(bus.out_vld), 0);
        @(negedge nclk);
        rst = 1'b0;
        #1;
        check("idle_in_rdy", 32'(bus.in_rdy), 1);
        check("idle_out_vld", 32'(bus.out_vld), 0);
        check("idle_occ", 32'(bus.occ), 0);
        check("idle_out_y", 32'(bus.out_y), 0);
        check("idle_out_par", 32'(bus.out_par), 0);
        @(negedge nclk);

        // 2: single push, one-cycle latency, then popped
        send(4'b1100, 4'b1010, 4'b0001, 4'b0110, 1'b0, w);
        check("t2_out_vld", 32'(bus.out_vld), 1);
        check("t2_occ1", 32'(bus.occ), 1);
        check("t2_out_y", 32'(bus.out_y), 32'b0110);
        @(negedge nclk);
        check("t2_occ0", 32'(bus.occ), 0);

        // 3: stall fills both entries; third offer held until space frees
        bus.out_rdy = 1'b0;
        send(4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0, w);
        send(4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, w);
        check("t3_occ2", 32'(bus.occ), 2);
        check("t3_in_rdy", 32'(bus.in_rdy), 0);
        fork
            send(4'b1111, 4'b0011, 4'b0100, 4'b1000, 1'b1, w);
            begin
                repeat (2) begin
                    check("t3_held_occ", 32'(bus.occ), 2);
                    @(negedge nclk);
                end
                bus.out_rdy = 1'b1;
            end
        join
        check("t3_wait", 32'(w), 3);
        repeat (3) @(negedge nclk);
        check("t3_drained", 32'(bus.occ), 0);

        // 4: back-to-back full throughput
        for (int i = 0; i < 8; i++) begin
            send(t4_a0[i], t4_a1[i], t4_b0[i], t4_y[i], t4_p[i], w);
            check("t4_no_stall", 32'(w), 0);
            check("t4_occ", 32'(bus.occ), 1);
        end
        @(negedge nclk);
        check("t4_occ_end", 32'(bus.occ), 0);

        // 5: activity freeze while full
        bus.out_rdy = 1'b0;
        send(4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, w);
        send(4'b0000, 4'b0000, 4'b0010, 4'b1101, 1'b1, w);
        act = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_vld = i[0] ? 1'b0 : 1'b1;
            bus.a0 = 4'b0101; bus.a1 = 4'b0011; bus.b0 = 4'b0000;
            bus.out_rdy = ~i[0];
            #1;
            check("t5_out_vld", 32'(bus.out_vld), 0);
            check("t5_in_rdy", 32'(bus.in_rdy), 0);
            check("t5_occ", 32'(bus.occ), 2);
            @(negedge nclk);
        end
        check("t5_occ_frozen", 32'(bus.occ), 2);
        check("t5_y_frozen", 32'(bus.out_y), 0);
        bus.in_vld = 1'b0; bus.a0 = 'x; bus.a1 = 'x; bus.b0 = 'x;
        act = 1'b1;
        bus.out_rdy = 1'b1;
        repeat (3) @(negedge nclk);
        check("t5_drained", 32'(bus.occ), 0);
        check("t5_q_empty", 32'(exp_q.size()), 0);

        // 6: reset while full discards both entries
        bus.out_rdy = 1'b0;
        send(4'b0101, 4'b0101, 4'b0000, 4'b1010, 1'b0, w);
        send(4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0, w);
        check("t6_occ2", 32'(bus.occ), 2);
        rst = 1'b1;
        bus.out_rdy = 1'b1;
        exp_q.delete();
        #1;
        check("t6_rst_out_vld", 32'(bus.out_vld), 0);
        check("t6_rst_in_rdy", 32'(bus.in_rdy), 0);
        @(negedge nclk);
        check("t6_occ0", 32'(bus.occ), 0);
        check("t6_out_y", 32'(bus.out_y), 0);
        check("t6_out_par", 32'(bus.out_par), 0);
        rst = 1'b0;
        #1;
        check("t6_out_vld", 32'(bus.out_vld), 0);
        repeat (4) @(negedge nclk);
        check("t6_occ_idle", 32'(bus.occ), 0);

        // Anything still queued never came out
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge nclk);
        check("final_q_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
